// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer encoding for both sides of the dual-clock FIFO.
package fifo_pkg;
   localparam int FIFO_ADDR_W = 3;
   localparam int PTR_MAX_W = 16;

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] v);
      return v ^ (v >> 1);
   endfunction

   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] v);
      logic [PTR_MAX_W-1:0] b;
      b[PTR_MAX_W-1] = v[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ v[i];
      return b;
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a Gray-coded pointer crossing domains.
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] q1;

   always_ff @(posedge clk) begin
      if (rst) begin
         q1 <= '0;
         q  <= '0;
      end else begin
         q1 <= d;
         q  <= q1;
      end
   end
endmodule

// File: rtl/r_ptr_and_empty.sv
// r_ptr_and_empty: read pointer, empty/almost-empty, level and underflow
// for the read side of the dual-clock FIFO.
module r_ptr_and_empty
   import fifo_pkg::*;
#(
   parameter int ADDR_W    = FIFO_ADDR_W,
   parameter int AE_THRESH = 1
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic              rd_en,
   input  logic [ADDR_W:0]   wr_ptr,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   rd_ptr,
   output logic [ADDR_W:0]   rd_level,
   output logic              rd_underflow
);
   localparam int PW = ADDR_W + 1;
   localparam logic [PW-1:0] AE = PW'(AE_THRESH);

   logic [PW-1:0] rq2_wptr, rd_bin, rd_bin_next, rd_gray_next, wbin, level_next;
   logic [PTR_MAX_W-1:0] gray_w, wbin_w;
   logic rd_inc;

   sync_2ff #(.W(PW)) u_sync (
      .clk(rd_clk),
      .rst(rd_rst),
      .d  (wr_ptr),
      .q  (rq2_wptr)
   );

   always_comb begin
      rd_inc       = rd_en & ~empty;
      rd_bin_next  = rd_bin + PW'(rd_inc);
      gray_w       = bin2gray(PTR_MAX_W'(rd_bin_next));
      rd_gray_next = gray_w[PW-1:0];
      wbin_w       = gray2bin(PTR_MAX_W'(rq2_wptr));
      wbin         = wbin_w[PW-1:0];
      level_next   = wbin - rd_bin_next;
   end

   assign rd_addr = rd_bin[ADDR_W-1:0];

   // empty uses the pre-edge rq2_wptr, so it can only ever be late, never early
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         rd_bin       <= '0;
         rd_ptr       <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_level     <= '0;
         rd_underflow <= 1'b0;
      end else begin
         rd_bin       <= rd_bin_next;
         rd_ptr       <= rd_gray_next;
         empty        <= rd_gray_next == rq2_wptr;
         almost_empty <= level_next <= AE;
         rd_level     <= level_next;
         rd_underflow <= rd_en & empty;
      end
   end
endmodule

// File: tb/tb_r_ptr_and_empty.sv
// tb_r_ptr_and_empty: randomized scoreboard bench against a count-based model.
module tb_r_ptr_and_empty;
   localparam int AW = 3;
   localparam int AE_T = 1;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      bit       emp;
      bit       ae;
      bit [2:0] addr;
      bit [3:0] ptr;
      bit [3:0] lvl;
      bit       uf;
      int       steps;
   } exp_t;

   logic rd_clk = 0, rd_rst = 1, rd_en = 0;
   logic [AW:0] wr_ptr = '0;
   logic empty, almost_empty, rd_underflow;
   logic [AW-1:0] rd_addr;
   logic [AW:0] rd_ptr, rd_level;

   int checks = 0, errors = 0;
   exp_t q[$];

   // model state: unbounded entry counts, synchroniser as a 2-deep history
   int wc = 0, rdm = 0, w1 = 0, w2 = 0;
   bit emp = 1;

   r_ptr_and_empty #(.ADDR_W(AW), .AE_THRESH(AE_T)) dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_en(rd_en), .wr_ptr(wr_ptr),
      .empty(empty), .almost_empty(almost_empty), .rd_addr(rd_addr),
      .rd_ptr(rd_ptr), .rd_level(rd_level), .rd_underflow(rd_underflow)
   );

   always #5 rd_clk = ~rd_clk;

   function automatic logic [3:0] gray(input int x);
      logic [3:0] b;
      b = 4'(x);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit e);
      exp_t x;
      int nrd;
      bit inc;
      rd_rst = r;
      rd_en  = e;
      wr_ptr = gray(wc);
      @(posedge rd_clk);
      if (r) begin
         rdm = 0; w1 = 0; w2 = 0; emp = 1;
         x = '{1'b1, 1'b1, 3'd0, 4'd0, 4'd0, 1'b0, -1};
      end else begin
         inc = e && !emp;
         nrd = rdm + int'(inc);
         x.emp   = (nrd == w2);
         x.lvl   = 4'(w2 - nrd);
         x.ae    = (w2 - nrd) <= AE_T;
         x.uf    = e && emp;
         x.addr  = 3'(nrd % DEPTH);
         x.ptr   = gray(nrd);
         x.steps = int'(inc);
         w2 = w1; w1 = wc; rdm = nrd; emp = x.emp;
      end
      q.push_back(x);
      #1;
   endtask

   logic [3:0] prev_ptr = '0;
   always @(negedge rd_clk) begin
      if (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         chk("empty", int'(empty), int'(x.emp));
         chk("almost_empty", int'(almost_empty), int'(x.ae));
         chk("rd_addr", int'(rd_addr), int'(x.addr));
         chk("rd_ptr", int'(rd_ptr), int'(x.ptr));
         chk("rd_level", int'(rd_level), int'(x.lvl));
         chk("rd_underflow", int'(rd_underflow), int'(x.uf));
         if (x.steps >= 0) chk("gray_bits_changed", $countones(rd_ptr ^ prev_ptr), x.steps);
         prev_ptr = rd_ptr;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset with a nonzero write pointer present
      wc = 4;
      repeat (2) step(1, 0);
      wc = 0;
      step(0, 0);
      // single entry, then read it
      wc = 1;
      repeat (3) step(0, 0);
      step(0, 1);
      repeat (2) step(0, 0);
      // fill to full after a fresh reset, then drain
      wc = 0;
      step(1, 0);
      wc = 8;
      repeat (3) step(0, 0);
      repeat (8) step(0, 1);
      step(0, 0);
      // underflow on empty
      repeat (3) step(0, 1);
      repeat (2) step(0, 0);
      // wrap with continuous reads
      for (int i = 9; i <= 20; i++) begin
         wc = i;
         step(0, 1);
      end
      repeat (4) step(0, 1);
      // random traffic bounded by depth
      for (int i = 0; i < 400; i++) begin
         if (wc - rdm < DEPTH && $urandom_range(0, 2) != 0) wc++;
         step(0, $urandom_range(0, 1) == 1);
      end
      repeat (4) step(0, 0);
      // build up level 5, then reset together with a read
      while (wc - rdm < 5) begin
         wc++;
         step(0, 0);
      end
      repeat (3) step(0, 0);
      wc = 0;
      step(1, 1);
      repeat (3) step(0, 1);
      wc = 2;
      repeat (4) step(0, 0);
      repeat (3) step(0, 1);
      @(negedge rd_clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
